// File: rtl/ssf_sample_port.sv
// SSF sample-port responder: buffers upstream samples and serves one per req_in
// advance, and captures io_out strobes into a show-ahead FIFO for a valid/ready sink.

module ssf_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

module ssf_sample_port #(
  parameter int DATA_W    = 32,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] sample_out,
  input  logic [1:0]        req_in,
  input  logic [DATA_W-1:0] io_out,
  input  logic [1:0]        out_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              clr_stats,
  output logic              primed,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic [CNT_W-1:0]  overflow_cnt,
  output logic [CNT_W-1:0]  proto_err_cnt
);
  typedef enum logic {PRIME, RUN} state_t;

  state_t            state, state_nxt;
  logic              in_push, in_pop, in_full, in_empty;
  logic [DATA_W-1:0] in_head;
  logic              out_push, out_pop, out_full, out_empty;
  logic              ur_ev, ovf_ev;
  logic [1:0]        proto_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign s_ready = !in_full;
  assign in_push = s_valid && s_ready;

  ssf_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .rst_n(rst_n), .push(in_push), .wdata(s_data),
    .pop(in_pop), .rdata(in_head), .full(in_full), .empty(in_empty)
  );

  always_comb begin
    state_nxt = state;
    in_pop    = 1'b0;
    ur_ev     = 1'b0;
    unique case (state)
      PRIME: if (!in_empty) begin
        in_pop    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (req_in == 2'd1) begin
        in_pop = !in_empty;
        ur_ev  = in_empty;
      end
      default: state_nxt = PRIME;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PRIME;
      sample_out <= '0;
      primed     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_pop) sample_out <= in_head;
      if (state == PRIME && state_nxt == RUN) primed <= 1'b1;
    end
  end

  // A full output FIFO still takes a write when its head leaves on the same edge.
  assign m_valid  = !out_empty;
  assign out_pop  = m_valid && m_ready;
  assign out_push = (out_en == 2'd1) && (!out_full || out_pop);
  assign ovf_ev   = (out_en == 2'd1) && out_full && !out_pop;

  ssf_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .rst_n(rst_n), .push(out_push), .wdata(io_out),
    .pop(out_pop), .rdata(m_data), .full(out_full), .empty(out_empty)
  );

  assign proto_inc = {1'b0, req_in[1]} + {1'b0, out_en[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun      <= 1'b0;
      underrun_cnt  <= '0;
      overflow_cnt  <= '0;
      proto_err_cnt <= '0;
    end else if (clr_stats) begin
      underrun      <= 1'b0;
      underrun_cnt  <= '0;
      overflow_cnt  <= '0;
      proto_err_cnt <= '0;
    end else begin
      if (ur_ev) underrun <= 1'b1;
      underrun_cnt  <= sat_add(underrun_cnt, {1'b0, ur_ev});
      overflow_cnt  <= sat_add(overflow_cnt, {1'b0, ovf_ev});
      proto_err_cnt <= sat_add(proto_err_cnt, proto_inc);
    end
  end
endmodule

// File: tb/tb_ssf_sample_port.sv
// Directed bench for ssf_sample_port: hand-computed expectations checked with
// immediate assertions, one linear stimulus sequence.

module tb_ssf_sample_port;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] sample_out;
  logic [1:0]        req_in;
  logic [DATA_W-1:0] io_out;
  logic [1:0]        out_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              clr_stats;
  logic              primed;
  logic              underrun;
  logic [CNT_W-1:0]  underrun_cnt;
  logic [CNT_W-1:0]  overflow_cnt;
  logic [CNT_W-1:0]  proto_err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ssf_sample_port dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sample_out(sample_out), .req_in(req_in), .io_out(io_out), .out_en(out_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .clr_stats(clr_stats),
    .primed(primed), .underrun(underrun), .underrun_cnt(underrun_cnt),
    .overflow_cnt(overflow_cnt), .proto_err_cnt(proto_err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".sample_out"}, sample_out, 0);
    check({tag, ".primed"}, primed, 0);
    check({tag, ".underrun"}, underrun, 0);
    check({tag, ".s_ready"}, s_ready, 1);
    check({tag, ".m_valid"}, m_valid, 0);
    check({tag, ".ur_cnt"}, underrun_cnt, 0);
    check({tag, ".ovf_cnt"}, overflow_cnt, 0);
    check({tag, ".proto_cnt"}, proto_err_cnt, 0);
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; req_in = 2'd0; io_out = '0;
    out_en = 2'd0; m_ready = 1'b0; clr_stats = 1'b0;
    #12;
    check_reset_state("reset");
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Priming: no bypass, the first sample appears one edge after it is poppable.
    s_valid = 1'b1; s_data = 32'd5; tick();
    check("prime.no_bypass", sample_out, 0);
    check("prime.not_primed", primed, 0);
    s_data = 32'hFFFF_FFF9; tick();
    check("prime.sample5", sample_out, 32'd5);
    check("prime.primed", primed, 1);
    s_data = 32'd12; tick();
    s_valid = 1'b0; tick();
    check("hold.sample5", sample_out, 32'd5);

    req_in = 2'd1; tick();
    check("req.minus7", sample_out, 32'hFFFF_FFF9);
    tick();
    check("req.twelve", sample_out, 32'd12);
    check("req.s_ready", s_ready, 1);
    tick();
    check("underrun.hold", sample_out, 32'd12);
    check("underrun.flag", underrun, 1);
    check("underrun.cnt", underrun_cnt, 1);
    req_in = 2'd0; s_valid = 1'b1; s_data = 32'd3; tick();
    s_valid = 1'b0; req_in = 2'd1; tick();
    check("req.three", sample_out, 32'd3);
    check("underrun.cnt_stable", underrun_cnt, 1);
    req_in = 2'd0;

    // Fill the input FIFO past its depth with no requests.
    acc = 0;
    for (int i = 0; i < 18; i++) begin
      s_valid = 1'b1; s_data = 32'(100 + i);
      if (s_ready) acc++;
      if (i < 16) tick();
    end
    check("fill.accepts", acc, 16);
    tick();
    check("fill.s_ready_low", s_ready, 0);
    check("fill.sample_hold", sample_out, 32'd3);
    s_data = 32'd116; req_in = 2'd1; tick();
    check("fill.pop100", sample_out, 32'd100);
    check("fill.space", s_ready, 1);
    req_in = 2'd0; tick();
    check("fill.refull", s_ready, 0);
    s_valid = 1'b0;

    // Output overflow with the sink stalled, then an ordered drain.
    for (int i = 0; i < 18; i++) begin
      out_en = 2'd1; io_out = 32'(i); tick();
    end
    out_en = 2'd0;
    check("ovf.cnt", overflow_cnt, 2);
    check("ovf.m_valid", m_valid, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain.d%0d", i), m_data, 64'(i));
      tick();
    end
    check("drain.empty", m_valid, 0);
    m_ready = 1'b0;

    // Write into a full FIFO while its head is accepted on the same edge.
    for (int i = 0; i < 16; i++) begin
      out_en = 2'd1; io_out = 32'(200 + i); tick();
    end
    io_out = 32'd216; m_ready = 1'b1; tick();
    out_en = 2'd0;
    check("fullpop.ovf_cnt", overflow_cnt, 2);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fullpop.d%0d", i), m_data, 64'(201 + i));
      tick();
    end
    check("fullpop.empty", m_valid, 0);
    m_ready = 1'b0;

    // Both protocol errors in one cycle count twice and change nothing else.
    out_en = 2'd1; io_out = 32'd77; tick();
    req_in = 2'd2; out_en = 2'd3; io_out = 32'd88; tick();
    req_in = 2'd0; out_en = 2'd0;
    check("proto.cnt", proto_err_cnt, 2);
    check("proto.sample_hold", sample_out, 32'd100);
    check("proto.m_data", m_data, 32'd77);
    check("proto.s_ready", s_ready, 0);

    // Clear wins over a coincident event and leaves primed alone.
    clr_stats = 1'b1; req_in = 2'd3; tick();
    clr_stats = 1'b0; req_in = 2'd0;
    check("clr.proto", proto_err_cnt, 0);
    check("clr.ovf", overflow_cnt, 0);
    check("clr.ur_cnt", underrun_cnt, 0);
    check("clr.underrun", underrun, 0);
    check("clr.primed", primed, 1);
    check("clr.m_valid", m_valid, 1);

    // Asynchronous reset mid-stream.
    rst_n = 1'b0; #1;
    check_reset_state("midrst");
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    check("postrst.sample", sample_out, 0);
    check("postrst.primed", primed, 0);
    check("postrst.m_valid", m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ssf_sample_port.md
Name: ssf_sample_port

Overview:
- Hardware counterpart of the SSF black-box sample interface: the responder side of the `req_in` / `out_en` protocol, replacing the file-driven bench in on-chip integration.
- Input side: buffers upstream samples in a FIFO and serves one held sample to the SSF core on each `req_in == 1` request.
- Output side: captures `io_out` on each `out_en == 1` strobe into a second FIFO, drained by a valid/ready master.
- Sits between the stream fabric and `ssfblackbox`.

Parameters:
- DATA_W, 32, sample width (signed two's complement, passed through unmodified).
- IN_DEPTH, 16, input FIFO entries (power of two, >= 2).
- OUT_DEPTH, 16, output FIFO entries (power of two, >= 2).
- CNT_W, 16, width of the underrun, overflow and protocol-error counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  upstream sample.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  input FIFO not full.
- sample_out  out  DATA_W  held sample; drives SSF `in`.
- req_in  in  2  SSF request code; 2'd1 = advance to the next sample.
- io_out  in  DATA_W  SSF result.
- out_en  in  2  SSF output strobe code; 2'd1 = `io_out` valid.
- m_data  out  DATA_W  output FIFO head.
- m_valid  out  1  output FIFO non-empty.
- m_ready  in  1  downstream accept.
- clr_stats  in  1  synchronous clear of counters and sticky flags.
- primed  out  1  first sample has been loaded into `sample_out`.
- underrun  out  1  sticky: a request arrived while the input FIFO was empty.
- underrun_cnt  out  CNT_W  count of unserved requests, saturating.
- overflow_cnt  out  CNT_W  count of dropped outputs, saturating.
- proto_err_cnt  out  CNT_W  count of `req_in` or `out_en` values of 2 or 3, saturating.

Behaviour:
- Reset (async assert, sync deassert use):
  - `sample_out` = 0; `primed` = 0; `underrun` = 0.
  - All counters = 0; both FIFOs empty; `m_valid` = 0; `s_ready` = 1.
  - Reset mid-operation discards all buffered data; no partial state survives.
- Input FIFO:
  - Push on `s_valid & s_ready`.
  - `s_ready` = !full, combinational from registered pointers.
  - A pushed sample is poppable no earlier than the next edge; there is no bypass into `sample_out`.
- FSM state PRIME (reset state):
  - `req_in` is ignored for serving, but proto-error counting still applies.
  - At the first edge with the FIFO non-empty: pop the head into `sample_out`, set `primed` = 1, go to RUN.
- FSM state RUN, at each edge:
  - `req_in == 2'd1` and FIFO non-empty: pop the head into `sample_out`; it is visible after that edge (1-cycle response, matching the SSF expectation that the new sample is present at the following edge).
  - `req_in == 2'd1` and FIFO empty: `sample_out` holds its previous value; `underrun` set; `underrun_cnt` +1. The request is NOT queued.
  - `req_in == 2'd0`: hold.
  - `req_in` of 2'd2 or 2'd3: hold; `proto_err_cnt` +1.
- RUN is left only by reset.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Output capture:
  - On an edge with `out_en == 2'd1`, write `io_out` into the output FIFO.
  - Output FIFO full, but `m_valid & m_ready` in the same cycle: write accepted.
  - Otherwise full: sample dropped, `overflow_cnt` +1.
  - `out_en` of 2'd2 or 2'd3: no write; `proto_err_cnt` +1.
  - `req_in` and `out_en` errors in the same cycle count +2.
- Output FIFO: show-ahead; `m_data` valid whenever `m_valid`; pop on `m_valid & m_ready`.
- Counters:
  - Saturate at all-ones.
  - `clr_stats` zeroes counters and `underrun` at the edge; it does not affect FIFOs or `primed`.
  - An event coinciding with `clr_stats` is lost; the result is 0.
- Pointers: `log2(DEPTH) + 1` bits, wrap-around, full/empty by MSB compare.
- Data is not modified: no sign extension or rounding, bit-exact pass-through.

Test Plan:
- Reset, then push 5, -7, 12 with `req_in` = 0 -> one cycle after the first push is poppable, `sample_out` = 5 and `primed` = 1; `sample_out` stays 5 until a request.
- Pulse `req_in` = 1 on two consecutive edges -> `sample_out` = -7 then 12; FIFO empty; `s_ready` = 1.
- Further `req_in` = 1 with FIFO empty -> `sample_out` holds 12; `underrun` = 1; `underrun_cnt` = 1. Then push 3 and request -> `sample_out` = 3.
- Push IN_DEPTH+2 samples with no requests -> `s_ready` drops after 16 accepts; the overflowing 2 are not accepted and remain on `s_valid` until space frees.
- Hold `m_ready` = 0 and strobe `out_en` = 1 eighteen times with `io_out` = 0..17 -> FIFO holds 0..15; `overflow_cnt` = 2. Then drain -> `m_data` sequence 0..15 exactly.
- Drive `req_in` = 2 and `out_en` = 3 in the same cycle -> `proto_err_cnt` += 2 and no state change. Assert `rst_n` = 0 mid-stream -> all outputs return to reset values immediately.
